// File: rtl/pcpi_div_pkg.sv
// Shared types and constants for the PCPI multi-step divider.
// Decode fields and the op/state encodings used by the top and the step datapath.
package pcpi_div_pkg;

    // The order matches funct3[1:0] of DIV/DIVU/REM/REMU.
    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    localparam logic [6:0] OPC_OP    = 7'h33;
    localparam logic [6:0] F7_MULDIV = 7'h01;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_div(input div_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/pcpi_div_step.sv
// Combinational slice of a restoring divider: STEPS compare/subtract/shift steps, MSB first.
// The divisor is pre-aligned so its low XLEN bits are the value to subtract at each step.
module pcpi_div_step
    import pcpi_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEPS = 1
) (
    input  logic [XLEN-1:0]   i_dividend,
    input  logic [2*XLEN-2:0] i_divisor,
    input  logic [XLEN-1:0]   i_quotient,
    input  logic [XLEN-1:0]   i_mask,
    output logic [XLEN-1:0]   o_dividend,
    output logic [2*XLEN-2:0] o_divisor,
    output logic [XLEN-1:0]   o_quotient,
    output logic [XLEN-1:0]   o_mask
);

    logic [XLEN-1:0]   w_dvd;
    logic [2*XLEN-2:0] w_dsr;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_msk;

    always_comb begin
        w_dvd = i_dividend;
        w_dsr = i_divisor;
        w_quo = i_quotient;
        w_msk = i_mask;
        for (int i = 0; i < STEPS; i++) begin
            // A fit implies the divisor's upper bits are zero, so an XLEN-bit subtract is exact.
            if (w_dsr <= {{(XLEN-1){1'b0}}, w_dvd}) begin
                w_dvd = w_dvd - w_dsr[XLEN-1:0];
                w_quo = w_quo | w_msk;
            end
            w_dsr = w_dsr >> 1;
            w_msk = w_msk >> 1;
        end
        o_dividend = w_dvd;
        o_divisor  = w_dsr;
        o_quotient = w_quo;
        o_mask     = w_msk;
    end

endmodule

// File: rtl/pcpi_div_multi.sv
// PCPI M-extension divider (DIV/DIVU/REM/REMU) retiring STEPS quotient bits per cycle,
// with single-cycle exits for divide-by-zero, signed overflow and a DIV/REM fusion cache.
module pcpi_div_multi
    import pcpi_div_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int STEPS   = 1,
    parameter int FUSE_EN = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_wait,
    output logic            pcpi_ready
);

    localparam int NITER = XLEN / STEPS;
    localparam int CNT_W = $clog2(NITER + 1);
    localparam int DW    = 2 * XLEN - 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e        r_state;
    div_state_e        w_state_next;
    div_op_e           r_op;
    logic [XLEN-1:0]   r_dividend;
    logic [DW-1:0]     r_divisor;
    logic [XLEN-1:0]   r_quotient;
    logic [XLEN-1:0]   r_mask;
    logic [CNT_W-1:0]  r_count;
    logic              r_qsign;
    logic              r_rsign;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;

    logic              r_c_valid;
    logic              r_c_signed;
    logic [XLEN-1:0]   r_c_rs1;
    logic [XLEN-1:0]   r_c_rs2;
    logic [XLEN-1:0]   r_c_q;
    logic [XLEN-1:0]   r_c_r;

    logic              r_ready;
    logic              r_wait;
    logic [XLEN-1:0]   r_rd;
    logic              w_ready_next;
    logic              w_wait_next;
    logic [XLEN-1:0]   w_rd_next;

    logic              w_match;
    logic              w_accept;
    logic              w_unused_insn;
    logic              w_signed;
    logic              w_is_div;
    logic              w_rs1_neg;
    logic              w_rs2_neg;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_rs2_zero;
    logic              w_ovf;
    logic              w_hit;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_rd;
    logic              w_last;
    logic              w_finish_iter;

    logic [XLEN-1:0]   w_dvd_step;
    logic [DW-1:0]     w_dsr_step;
    logic [XLEN-1:0]   w_quo_step;
    logic [XLEN-1:0]   w_msk_step;
    logic [XLEN-1:0]   w_q_corr;
    logic [XLEN-1:0]   w_r_corr;
    logic [XLEN-1:0]   w_iter_rd;

    // Register-number fields play no part in the result.
    assign w_unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    assign w_match = (pcpi_insn[6:0] == OPC_OP) && (pcpi_insn[31:25] == F7_MULDIV) &&
                     ((pcpi_insn[14:12] == F3_DIV) || (pcpi_insn[14:12] == F3_DIVU) ||
                      (pcpi_insn[14:12] == F3_REM) || (pcpi_insn[14:12] == F3_REMU));
    assign w_accept = pcpi_valid && w_match && !r_ready;

    assign w_signed   = op_is_signed(r_op);
    assign w_is_div   = op_is_div(r_op);
    assign w_rs1_neg  = w_signed && pcpi_rs1[XLEN-1];
    assign w_rs2_neg  = w_signed && pcpi_rs2[XLEN-1];
    assign w_abs1     = w_rs1_neg ? -pcpi_rs1 : pcpi_rs1;
    assign w_abs2     = w_rs2_neg ? -pcpi_rs2 : pcpi_rs2;
    assign w_rs2_zero = (pcpi_rs2 == '0);
    assign w_ovf      = w_signed && (pcpi_rs1 == MIN_VAL) && (pcpi_rs2 == '1);
    assign w_hit      = (FUSE_EN != 0) && r_c_valid && (r_c_signed == w_signed) &&
                        (r_c_rs1 == pcpi_rs1) && (r_c_rs2 == pcpi_rs2);
    assign w_fast     = w_rs2_zero || w_ovf || w_hit;

    always_comb begin
        w_fast_rd = '0;
        if (w_rs2_zero) begin
            w_fast_rd = w_is_div ? '1 : pcpi_rs1;
        end else if (w_ovf) begin
            w_fast_rd = w_is_div ? MIN_VAL : '0;
        end else if (w_hit) begin
            w_fast_rd = w_is_div ? r_c_q : r_c_r;
        end
    end

    pcpi_div_step #(
        .XLEN  (XLEN),
        .STEPS (STEPS)
    ) u_step (
        .i_dividend (r_dividend),
        .i_divisor  (r_divisor),
        .i_quotient (r_quotient),
        .i_mask     (r_mask),
        .o_dividend (w_dvd_step),
        .o_divisor  (w_dsr_step),
        .o_quotient (w_quo_step),
        .o_mask     (w_msk_step)
    );

    assign w_q_corr      = r_qsign ? -w_quo_step : w_quo_step;
    assign w_r_corr      = r_rsign ? -w_dvd_step : w_dvd_step;
    assign w_iter_rd     = w_is_div ? w_q_corr : w_r_corr;
    assign w_last        = (r_count == CNT_W'(1));
    assign w_finish_iter = (r_state == S_ITER) && pcpi_valid && w_last;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Dropping pcpi_valid while busy abandons the operation silently.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_LOAD;
            S_LOAD: begin
                if (!pcpi_valid)  w_state_next = S_IDLE;
                else if (w_fast)  w_state_next = S_DONE;
                else              w_state_next = S_ITER;
            end
            S_ITER: begin
                if (!pcpi_valid)  w_state_next = S_IDLE;
                else if (w_last)  w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready_next = (w_state_next == S_DONE);
        w_wait_next  = (w_state_next == S_LOAD) || (w_state_next == S_ITER);
        w_rd_next    = '0;
        if (w_state_next == S_DONE) begin
            w_rd_next = (r_state == S_LOAD) ? w_fast_rd : w_iter_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_wait  <= 1'b0;
            r_rd    <= '0;
        end else begin
            r_ready <= w_ready_next;
            r_wait  <= w_wait_next;
            r_rd    <= w_rd_next;
        end
    end

    assign pcpi_ready = r_ready;
    assign pcpi_wr    = r_ready;
    assign pcpi_wait  = r_wait;
    assign pcpi_rd    = r_rd;

    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (w_accept) r_op <= div_op_e'(pcpi_insn[13:12]);
            end
            S_LOAD: begin
                r_rs1      <= pcpi_rs1;
                r_rs2      <= pcpi_rs2;
                r_dividend <= w_abs1;
                r_divisor  <= {w_abs2, {(XLEN-1){1'b0}}};
                r_quotient <= '0;
                r_mask     <= MIN_VAL;
                r_count    <= CNT_W'(NITER);
                r_qsign    <= (w_rs1_neg ^ w_rs2_neg) && !w_rs2_zero;
                r_rsign    <= w_rs1_neg;
            end
            S_ITER: begin
                r_dividend <= w_dvd_step;
                r_divisor  <= w_dsr_step;
                r_quotient <= w_quo_step;
                r_mask     <= w_msk_step;
                r_count    <= r_count - CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Both signed-corrected halves are kept so a following DIV/REM twin completes in one step.
    always_ff @(posedge clk) begin
        if (w_finish_iter) begin
            r_c_rs1    <= r_rs1;
            r_c_rs2    <= r_rs2;
            r_c_signed <= w_signed;
            r_c_q      <= w_q_corr;
            r_c_r      <= w_r_corr;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_c_valid <= 1'b0;
        end else if (w_finish_iter && (FUSE_EN != 0)) begin
            r_c_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pcpi_div_multi.sv
// Directed bench for pcpi_div_multi: a 32-bit/1-step instance and a 64-bit/4-step instance.
module tb_pcpi_div_multi;

    logic        clk = 1'b0;
    logic        resetn;
    logic        va, vb;
    logic [31:0] insn_a, insn_b;
    logic [31:0] a1, a2;
    logic [63:0] b1, b2;
    logic        wr_a, wait_a, ready_a;
    logic [31:0] rd_a;
    logic        wr_b, wait_b, ready_b;
    logic [63:0] rd_b;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] res_rd;
    int          res_cyc;
    logic        res_wr, res_wait1, res_got;
    int          seen;

    always #5 clk = ~clk;

    pcpi_div_multi #(.XLEN(32), .STEPS(1), .FUSE_EN(1)) u_dut32 (
        .clk(clk), .resetn(resetn), .pcpi_valid(va), .pcpi_insn(insn_a),
        .pcpi_rs1(a1), .pcpi_rs2(a2), .pcpi_wr(wr_a), .pcpi_rd(rd_a),
        .pcpi_wait(wait_a), .pcpi_ready(ready_a)
    );

    pcpi_div_multi #(.XLEN(64), .STEPS(4), .FUSE_EN(1)) u_dut64 (
        .clk(clk), .resetn(resetn), .pcpi_valid(vb), .pcpi_insn(insn_b),
        .pcpi_rs1(b1), .pcpi_rs2(b2), .pcpi_wr(wr_b), .pcpi_rd(rd_b),
        .pcpi_wait(wait_b), .pcpi_ready(ready_b)
    );

    function automatic logic [31:0] mk(input logic [2:0] f3);
        return {7'h01, 5'd2, 5'd1, f3, 5'd3, 7'h33};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one instruction and waits (bounded) for ready; valid stays high on return.
    task automatic issue(input bit sel, input string tag, input logic [2:0] f3,
                         input logic [63:0] x, input logic [63:0] y, input bit same_cycle);
        if (!same_cycle) begin
            @(posedge clk); #1;
        end
        if (sel) begin
            vb = 1'b1; insn_b = mk(f3); b1 = x; b2 = y;
        end else begin
            va = 1'b1; insn_a = mk(f3); a1 = x[31:0]; a2 = y[31:0];
        end
        res_got = 1'b0; res_cyc = 0; res_rd = '0; res_wr = 1'b0; res_wait1 = 1'b0;
        while (!res_got && res_cyc < 200) begin
            @(posedge clk); #1;
            res_cyc++;
            if (res_cyc == 1) res_wait1 = sel ? wait_b : wait_a;
            if (sel ? ready_b : ready_a) begin
                res_got = 1'b1;
                res_rd  = sel ? rd_b : {32'h0, rd_a};
                res_wr  = sel ? wr_b : wr_a;
            end
        end
        chk({tag, "_done"}, 64'(res_got), 64'd1);
        $display("op %s f3=%0d rs1=%h rs2=%h -> rd=%h cycle=%0d", tag, f3, x, y, res_rd, res_cyc);
    endtask

    task automatic release_idle(input bit sel, input string tag);
        va = 1'b0; vb = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_post_ready"}, 64'(sel ? ready_b : ready_a), 64'd0);
        chk({tag, "_post_wait"},  64'(sel ? wait_b : wait_a),   64'd0);
        chk({tag, "_post_rd"},    sel ? rd_b : {32'h0, rd_a},   64'd0);
    endtask

    task automatic op(input bit sel, input string tag, input logic [2:0] f3,
                      input logic [63:0] x, input logic [63:0] y,
                      input logic [63:0] exp_rd, input int exp_cyc);
        issue(sel, tag, f3, x, y, 1'b0);
        chk({tag, "_rd"},    res_rd, exp_rd);
        chk({tag, "_cycle"}, 64'(res_cyc), 64'(exp_cyc));
        chk({tag, "_wr"},    64'(res_wr), 64'd1);
        release_idle(sel, tag);
    endtask

    initial begin
        logic [63:0] x, y, e;
        logic [2:0]  f3;

        resetn = 1'b0; va = 1'b0; vb = 1'b0;
        insn_a = '0; insn_b = '0; a1 = '0; a2 = '0; b1 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", 64'(ready_a), 64'd0);
        chk("rst_wr_a",    64'(wr_a),    64'd0);
        chk("rst_wait_a",  64'(wait_a),  64'd0);
        chk("rst_rd_a",    {32'h0, rd_a}, 64'd0);
        chk("rst_ready_b", 64'(ready_b), 64'd0);
        chk("rst_rd_b",    rd_b,         64'd0);
        resetn = 1'b1;

        // Full-latency unsigned divide with wait asserted from cycle 1.
        issue(1'b0, "divu_100_7", 3'd5, 64'd100, 64'd7, 1'b0);
        chk("divu_100_7_rd",    res_rd, 64'd14);
        chk("divu_100_7_cycle", 64'(res_cyc), 64'd34);
        chk("divu_100_7_wr",    64'(res_wr), 64'd1);
        chk("divu_100_7_wait1", 64'(res_wait1), 64'd1);
        release_idle(1'b0, "divu_100_7");

        op(1'b0, "div_m7_2",  3'd4, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 34);
        op(1'b0, "rem_m7_2",  3'd6, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 2);
        op(1'b0, "remu_7_0",  3'd7, 64'd7, 64'd0, 64'd7, 2);

        // Divide-by-zero, then a back-to-back overflow case presented during the DONE cycle.
        issue(1'b0, "div_5_0", 3'd4, 64'd5, 64'd0, 1'b0);
        chk("div_5_0_rd",    res_rd, 64'hFFFFFFFF);
        chk("div_5_0_cycle", 64'(res_cyc), 64'd2);
        issue(1'b0, "div_min_m1_b2b", 3'd4, 64'h80000000, 64'hFFFFFFFF, 1'b1);
        chk("div_min_m1_rd",    res_rd, 64'h80000000);
        chk("div_min_m1_cycle", 64'(res_cyc), 64'd3);
        release_idle(1'b0, "div_min_m1");
        op(1'b0, "rem_min_m1", 3'd6, 64'h80000000, 64'hFFFFFFFF, 64'd0, 2);

        // Fusion: REM reuses the DIV result, REMU differs in signedness.
        op(1'b0, "div_1000_33",  3'd4, 64'd1000, 64'd33, 64'd30, 34);
        op(1'b0, "rem_1000_33",  3'd6, 64'd1000, 64'd33, 64'd10, 2);
        op(1'b0, "remu_1000_33", 3'd7, 64'd1000, 64'd33, 64'd10, 34);

        // Non-matching instructions: MUL (funct3=0) and XOR-like (funct7=0).
        @(posedge clk); #1;
        va = 1'b1; insn_a = {7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}; a1 = 32'd9; a2 = 32'd3;
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (ready_a || wait_a) seen++; end
        insn_a = {7'h00, 5'd2, 5'd1, 3'd4, 5'd3, 7'h33};
        repeat (6) begin @(posedge clk); #1; if (ready_a || wait_a) seen++; end
        chk("nomatch_response", 64'(seen), 64'd0);
        $display("op nomatch -> response_cycles=%0d", seen);
        va = 1'b0;

        // Abort by dropping valid mid-iteration; cache must still hold unsigned 1000/33.
        @(posedge clk); #1;
        va = 1'b1; insn_a = mk(3'd5); a1 = 32'd500; a2 = 32'd7;
        seen = 0;
        repeat (5) begin @(posedge clk); #1; if (ready_a) seen++; end
        va = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (ready_a) seen++; end
        chk("abort_no_ready", 64'(seen), 64'd0);
        chk("abort_wait",     64'(wait_a), 64'd0);
        $display("op abort divu 500/7 -> ready_count=%0d", seen);
        op(1'b0, "divu_1000_33_hit", 3'd5, 64'd1000, 64'd33, 64'd30, 2);

        // Reset in ITER cycle 10 aborts and invalidates the cache.
        op(1'b0, "divu_9_3_fill", 3'd5, 64'd9, 64'd3, 64'd3, 34);
        @(posedge clk); #1;
        va = 1'b1; insn_a = mk(3'd5); a1 = 32'd100; a2 = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0; va = 1'b0;
        seen = 0;
        repeat (2) begin @(posedge clk); #1; if (ready_a) seen++; end
        chk("rst_mid_wait", 64'(wait_a), 64'd0);
        resetn = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (ready_a) seen++; end
        chk("rst_mid_no_ready", 64'(seen), 64'd0);
        $display("op reset mid-iter -> ready_count=%0d", seen);
        op(1'b0, "divu_9_3_after_rst", 3'd5, 64'd9, 64'd3, 64'd3, 34);

        // 64-bit, 4 bits per cycle.
        op(1'b1, "divu64_big", 3'd5, 64'h8000000000000005, 64'd3, 64'h2AAAAAAAAAAAAAAC, 18);
        op(1'b1, "div64_m100_7", 3'd4, -64'sd100, 64'd7, 64'hFFFFFFFFFFFFFFF2, 18);
        for (int i = 0; i < 8; i++) begin
            f3 = 3'(4 + (i % 4));
            x  = {$urandom, $urandom};
            y  = {$urandom, $urandom} >> $urandom_range(1, 62);
            if (y == 64'd0) y = 64'd1;
            case (f3)
                3'd4:    e = $signed(x) / $signed(y);
                3'd5:    e = x / y;
                3'd6:    e = $signed(x) % $signed(y);
                default: e = x % y;
            endcase
            op(1'b1, "rand64", f3, x, y, e, 18);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
